issue_csr_fifo: RTL and testbench
=================================

Name: issue_csr_fifo

Overview:
- Issue-to-CSR-execute queue: the producer end of the issue_csr_fifo handshake that execute_csr consumes.
- The issue stage pushes issue_execute_pack_t entries. The block presents the head entry as show-ahead data_out/data_out_valid and retires it on execute_csr's pop.
- A commit-stage flush empties the queue.

Parameters:
- DEPTH, 4, number of entries; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- issue_csr_fifo_push  in  1  issue stage writes data_in this cycle.
- issue_csr_fifo_data_in  in  issue_execute_pack_t  entry to enqueue.
- issue_csr_fifo_full  out  1  count == DEPTH.
- issue_csr_fifo_count  out  CNT_W  current occupancy.
- issue_csr_fifo_data_out  out  issue_execute_pack_t  head entry (show-ahead).
- issue_csr_fifo_data_out_valid  out  1  head entry present.
- issue_csr_fifo_pop  in  1  execute_csr consumes the head this cycle.
- commit_feedback_pack  in  commit_feedback_pack_t  flush = enable && flush.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH registers of issue_execute_pack_t.
  - rptr and wptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - count = wptr - rptr, modulo 2^CNT_W.
  - empty when rptr == wptr. full when the index bits are equal and the wrap bits differ.
- Reset (rst low, asynchronous): rptr = wptr = 0, count = 0, full = 0, data_out_valid = 0.
  - data_out reads slot 0. Its contents are don't-care while valid = 0; storage is not cleared.
- Outputs:
  - data_out = mem[rptr index], combinational from registers.
  - data_out_valid = !empty.
- Push accepted iff push && !full: mem[wptr] <= data_in and wptr++. A push while full is dropped silently, with no state change.
- Pop accepted iff pop && !empty: rptr++. A pop while empty is ignored.
- Simultaneous accepted push and pop:
  - Both pointers advance and count is unchanged.
  - When full, push && pop: the pop is accepted and the push is dropped, because full is registered. The producer must gate push on full.
- Flush (commit_feedback_pack.enable && commit_feedback_pack.flush), sampled at the rising edge:
  - rptr <= 0 and wptr <= 0, so the next cycle has count = 0 and data_out_valid = 0.
  - Flush has priority over a same-cycle push or pop; both are discarded.
- Wrap-around: the index wraps modulo DEPTH and the wrap bit toggles. Order is preserved across wrap.
- Latency: a pushed entry appears on data_out_valid the cycle after the push edge (the bypass feature changes this).
- No X propagation on control outputs at any time after reset release.

Optional Feature:
- Macro: ISSUE_CSR_FIFO_BYPASS_EN.
- Defined: when the queue is empty and push && !flush, data_out = data_in and data_out_valid = 1 combinationally in the same cycle.
  - If pop is also asserted that cycle, the entry is consumed directly and never written; pointers are unchanged.
  - If pop is not asserted, the entry is written normally.
- Undefined: no bypass. data_out_valid depends only on registered pointers, and there is no combinational path from push/data_in to the outputs.

Test Plan:
- Reset: hold rst = 0 for 2 cycles, release -> data_out_valid = 0, full = 0, count = 0. Pop = 1 on an empty queue -> count stays 0.
- Fill and overflow: push entries with rob_id 1..5 on consecutive cycles, no pop -> count 1,2,3,4,4 and full = 1 after the 4th push; the 5th is dropped. Pop 4 times -> data_out.rob_id sequence 1,2,3,4, then valid = 0.
- Wrap-around: perform 6 push/pop pairs interleaved with occupancy 1..3 (rob_id 10..15) -> output order 10..15 exact; count returns to 0.
- Simultaneous: with count = 2 (rob_id 20,21), push rob_id 22 and pop in the same cycle -> count stays 2 and head becomes 21. At full (4 entries), push rob_id 30 + pop -> count 3 and entry 30 absent.
- Flush: with count = 3, assert commit_feedback_pack.enable = 1, flush = 1 together with push rob_id 40 -> next cycle count = 0, data_out_valid = 0. A subsequent push of rob_id 41 -> head rob_id 41.
- Bypass (macro defined): on an empty queue, push rob_id 50 with pop = 1 -> same-cycle data_out.rob_id = 50, valid = 1; next cycle count = 0. Macro undefined: same stimulus -> same-cycle valid = 0; next cycle count = 1, head 50.

Source files
------------

// File: rtl/issue_csr_fifo_if.sv
// ---------------------------------------------------------------------------
// issue_csr_fifo_pkg / issue_csr_fifo_if
//
// Purpose : shared entry types and the handshake bundle between the issue
//           stage (producer), the issue_csr_fifo queue and execute_csr
//           (consumer).
//
// Interface signals:
//   issue_csr_fifo_push           issue stage writes data_in this cycle
//   issue_csr_fifo_data_in        entry to enqueue
//   issue_csr_fifo_full           queue holds DEPTH entries
//   issue_csr_fifo_count          current occupancy (CNT_W bits)
//   issue_csr_fifo_data_out       head entry (show-ahead)
//   issue_csr_fifo_data_out_valid head entry present
//   issue_csr_fifo_pop            execute_csr consumes the head this cycle
//
// Modports: master = issue/execute side, slave = the queue itself.
// ---------------------------------------------------------------------------
package issue_csr_fifo_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  rob_id;
        logic [2:0]  csr_op;
        logic [11:0] csr_addr;
        logic [31:0] src1;
        logic [4:0]  rd_addr;
        logic        rd_we;
    } issue_execute_pack_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

endpackage

interface issue_csr_fifo_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                                    issue_csr_fifo_push;
    issue_csr_fifo_pkg::issue_execute_pack_t issue_csr_fifo_data_in;
    logic                                    issue_csr_fifo_full;
    logic [CNT_W-1:0]                        issue_csr_fifo_count;
    issue_csr_fifo_pkg::issue_execute_pack_t issue_csr_fifo_data_out;
    logic                                    issue_csr_fifo_data_out_valid;
    logic                                    issue_csr_fifo_pop;

    modport master (
        output issue_csr_fifo_push,
        output issue_csr_fifo_data_in,
        output issue_csr_fifo_pop,
        input  issue_csr_fifo_full,
        input  issue_csr_fifo_count,
        input  issue_csr_fifo_data_out,
        input  issue_csr_fifo_data_out_valid
    );

    modport slave (
        input  issue_csr_fifo_push,
        input  issue_csr_fifo_data_in,
        input  issue_csr_fifo_pop,
        output issue_csr_fifo_full,
        output issue_csr_fifo_count,
        output issue_csr_fifo_data_out,
        output issue_csr_fifo_data_out_valid
    );

endinterface

// File: rtl/issue_csr_fifo.sv
// ---------------------------------------------------------------------------
// issue_csr_fifo
//
// Purpose : issue-to-CSR-execute queue. The issue stage pushes
//           issue_execute_pack_t entries; the head entry is presented
//           show-ahead and retired on execute_csr's pop. A commit-stage
//           flush (enable && flush) empties the queue and has priority over
//           any same-cycle push or pop.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   bus                   issue_csr_fifo_if.slave handshake bundle
//   commit_feedback_pack  commit-stage feedback, flush = enable && flush
//
// Parameters:
//   DEPTH  number of entries, power of 2, >= 2
//
// Optional feature (macro ISSUE_CSR_FIFO_BYPASS_EN):
//   defined   - on an empty queue a non-flushed push is visible on data_out
//               in the same cycle; if it is also popped it is never stored.
//   undefined - outputs depend only on registered state.
// ---------------------------------------------------------------------------
module issue_csr_fifo
    import issue_csr_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    issue_csr_fifo_if.slave       bus,
    input  commit_feedback_pack_t commit_feedback_pack
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Pointers carry one extra wrap bit above the slot index.
    logic [CNT_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    wptr_q, wptr_d;
    issue_execute_pack_t mem_q [DEPTH];
    issue_execute_pack_t mem_d [DEPTH];

    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic             empty;
    logic             full;
    logic             flush;
    logic             push_acc;
    logic             pop_acc;
    logic             bypass_take;

    assign ridx  = rptr_q[IDX_W-1:0];
    assign widx  = wptr_q[IDX_W-1:0];
    assign empty = (rptr_q == wptr_q);
    assign full  = (ridx == widx) && (rptr_q[IDX_W] != wptr_q[IDX_W]);
    assign flush = commit_feedback_pack.enable && commit_feedback_pack.flush;

    assign push_acc = bus.issue_csr_fifo_push && !full;
    assign pop_acc  = bus.issue_csr_fifo_pop && !empty;

`ifdef ISSUE_CSR_FIFO_BYPASS_EN
    logic bypass_vis;

    // Empty queue: a non-flushed push is forwarded straight to the consumer.
    assign bypass_vis  = empty && bus.issue_csr_fifo_push && !flush;
    // Forwarded and consumed in the same cycle: never stored.
    assign bypass_take = bypass_vis && bus.issue_csr_fifo_pop;

    assign bus.issue_csr_fifo_data_out       = bypass_vis ? bus.issue_csr_fifo_data_in
                                                          : mem_q[ridx];
    assign bus.issue_csr_fifo_data_out_valid = !empty || bypass_vis;
`else
    assign bypass_take = 1'b0;

    assign bus.issue_csr_fifo_data_out       = mem_q[ridx];
    assign bus.issue_csr_fifo_data_out_valid = !empty;
`endif

    assign bus.issue_csr_fifo_full  = full;
    assign bus.issue_csr_fifo_count = wptr_q - rptr_q;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        mem_d  = mem_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (push_acc && !bypass_take) begin
                mem_d[widx] = bus.issue_csr_fifo_data_in;
                wptr_d      = wptr_q + CNT_W'(1);
            end
            if (pop_acc) begin
                rptr_d = rptr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    // Storage is deliberately left out of reset; valid masks stale slots.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_issue_csr_fifo.sv
// ---------------------------------------------------------------------------
// tb_issue_csr_fifo
//
// Bench for issue_csr_fifo (DEPTH = 4). A queue-based reference model is
// advanced on every rising edge and compared against the DUT on every
// falling edge; directed sequences add literal expectations on top.
// Inputs change 2 time units after the rising edge, literal checks happen
// 4 units after it, model comparisons at the falling edge (5 units).
// ---------------------------------------------------------------------------
module tb_issue_csr_fifo;
    import issue_csr_fifo_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    commit_feedback_pack_t cfp;

    issue_csr_fifo_if #(.DEPTH(DEPTH)) bus ();

    issue_csr_fifo #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .commit_feedback_pack (cfp)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 1'b0;

    issue_execute_pack_t model_q [$];
    int unsigned         m_sz;
    bit                  m_fl;
    bit                  m_bp;

    issue_execute_pack_t exp_data;
    bit                  exp_valid;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic issue_execute_pack_t mk(input int unsigned rob);
        issue_execute_pack_t p;
        p          = '0;
        p.pc       = 32'h0000_1000 + rob * 4;
        p.rob_id   = rob[5:0];
        p.csr_op   = rob[2:0];
        p.csr_addr = 12'h300 + rob[11:0];
        p.src1     = 32'hA5A5_0000 ^ rob;
        p.rd_addr  = rob[4:0];
        p.rd_we    = rob[0];
        return p;
    endfunction

    task automatic idle();
        bus.issue_csr_fifo_push    = 1'b0;
        bus.issue_csr_fifo_pop     = 1'b0;
        bus.issue_csr_fifo_data_in = '0;
        cfp                        = '0;
    endtask

    task automatic drv(input bit push, input int unsigned rob, input bit pop,
                       input bit en, input bit fl);
        bus.issue_csr_fifo_push    = push;
        bus.issue_csr_fifo_data_in = push ? mk(rob) : '0;
        bus.issue_csr_fifo_pop     = pop;
        cfp.enable                 = en;
        cfp.flush                  = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic look();
        #2;
    endtask

    // Reference model: a plain FIFO queue of entries.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
        end else begin
            m_sz = model_q.size();
            m_fl = cfp.enable && cfp.flush;
            m_bp = 1'b0;
`ifdef ISSUE_CSR_FIFO_BYPASS_EN
            m_bp = (m_sz == 0) && bus.issue_csr_fifo_push && bus.issue_csr_fifo_pop;
`endif
            if (m_fl) begin
                model_q.delete();
            end else if (!m_bp) begin
                if (bus.issue_csr_fifo_pop && m_sz > 0)
                    void'(model_q.pop_front());
                if (bus.issue_csr_fifo_push && m_sz < DEPTH)
                    model_q.push_back(bus.issue_csr_fifo_data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_valid = (model_q.size() > 0);
            exp_data  = exp_valid ? model_q[0] : '0;
`ifdef ISSUE_CSR_FIFO_BYPASS_EN
            if (model_q.size() == 0 && bus.issue_csr_fifo_push && !(cfp.enable && cfp.flush)) begin
                exp_valid = 1'b1;
                exp_data  = bus.issue_csr_fifo_data_in;
            end
`endif
            chk("m_count", 128'(bus.issue_csr_fifo_count), 128'(model_q.size()));
            chk("m_full", 128'(bus.issue_csr_fifo_full), 128'(model_q.size() == DEPTH));
            chk("m_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(exp_valid));
            if (exp_valid)
                chk("m_data", 128'(bus.issue_csr_fifo_data_out), 128'(exp_data));
        end
    end

    bit          wr_is_push [12] = '{1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    int unsigned next_push;
    int unsigned next_pop;

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
        chk("rst_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        rst    = 1'b1;
        chk_en = 1'b1;

        // Reset state and pop on empty
        drv(0, 0, 1, 0, 0);
        look();
        chk("empty_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
        chk("empty_full", 128'(bus.issue_csr_fifo_full), 128'(0));
        chk("empty_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        cyc();
        look();
        chk("pop_empty_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        cyc();

        // Fill 1..5, fifth dropped
        for (int i = 1; i <= 5; i++) begin
            drv(1, i, 0, 0, 0);
            look();
            chk("fill_count", 128'(bus.issue_csr_fifo_count), 128'((i - 1 > 4) ? 4 : i - 1));
            cyc();
        end
        look();
        chk("fill_count4", 128'(bus.issue_csr_fifo_count), 128'(4));
        chk("fill_full", 128'(bus.issue_csr_fifo_full), 128'(1));
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 1, 0, 0);
            look();
            chk("drain_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(1));
            chk("drain_rob", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(k));
            cyc();
        end
        look();
        chk("drain_done_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
        cyc();

        // Wrap-around with occupancy 1..3
        next_push = 10;
        next_pop  = 10;
        for (int j = 0; j < 12; j++) begin
            if (wr_is_push[j]) begin
                drv(1, next_push, 0, 0, 0);
                next_push++;
            end else begin
                drv(0, 0, 1, 0, 0);
            end
            look();
            if (!wr_is_push[j]) begin
                chk("wrap_rob", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(next_pop));
                next_pop++;
            end
            cyc();
        end
        look();
        chk("wrap_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        cyc();

        // Simultaneous push + pop
        drv(1, 20, 0, 0, 0); look(); cyc();
        drv(1, 21, 0, 0, 0); look(); cyc();
        drv(1, 22, 1, 0, 0);
        look();
        chk("sim_head_before", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(20));
        cyc();
        look();
        chk("sim_count", 128'(bus.issue_csr_fifo_count), 128'(2));
        chk("sim_head_after", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(21));
        cyc();
        drv(1, 23, 0, 0, 0); look(); cyc();
        drv(1, 24, 0, 0, 0); look(); cyc();
        look();
        chk("sim_full", 128'(bus.issue_csr_fifo_full), 128'(1));
        drv(1, 30, 1, 0, 0);
        cyc();
        look();
        chk("full_pp_count", 128'(bus.issue_csr_fifo_count), 128'(3));
        chk("full_pp_head", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(22));
        cyc();
        for (int k = 22; k <= 24; k++) begin
            drv(0, 0, 1, 0, 0);
            look();
            chk("full_pp_drain", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(k));
            cyc();
        end
        look();
        chk("full_pp_no30", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
        cyc();

        // Flush with same-cycle push
        for (int i = 1; i <= 3; i++) begin
            drv(1, i, 0, 0, 0); look(); cyc();
        end
        look();
        chk("pre_flush_count", 128'(bus.issue_csr_fifo_count), 128'(3));
        drv(1, 40, 0, 1, 1);
        cyc();
        look();
        chk("flush_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        chk("flush_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
        // flush without enable must not clear
        drv(1, 41, 0, 0, 1);
        cyc();
        look();
        chk("post_flush_count", 128'(bus.issue_csr_fifo_count), 128'(1));
        chk("post_flush_head", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(41));
        drv(0, 0, 1, 0, 0);
        cyc();
        look();
        chk("post_flush_empty", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
        cyc();

        // Push + pop on empty queue
        drv(1, 50, 1, 0, 0);
        look();
`ifdef ISSUE_CSR_FIFO_BYPASS_EN
        chk("byp_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(1));
        chk("byp_rob", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(50));
`else
        chk("nobyp_valid", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
`endif
        cyc();
        look();
`ifdef ISSUE_CSR_FIFO_BYPASS_EN
        chk("byp_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        chk("byp_valid_after", 128'(bus.issue_csr_fifo_data_out_valid), 128'(0));
`else
        chk("nobyp_count", 128'(bus.issue_csr_fifo_count), 128'(1));
        chk("nobyp_head", 128'(bus.issue_csr_fifo_data_out.rob_id), 128'(50));
        drv(0, 0, 1, 0, 0);
`endif
        cyc();
        look();
        chk("final_count", 128'(bus.issue_csr_fifo_count), 128'(0));
        cyc();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
